// File: rtl/colpar_pkg.sv
// Shared types and constants for the column-parity slice scheduler.
package colpar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_RD,
        PRE_LD,
        RD,
        INIT,
        RUN,
        WR,
        FIN
    } colpar_state_t;

    localparam int LANES      = 25;
    localparam int RUN_STEPS  = 25;
    localparam int WDOG_LIMIT = 32;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT);

endpackage

// File: rtl/colpar_scheduler_if.sv
// Round-controller handshake plus slice-memory and datapath strobes of the scheduler.
interface colpar_scheduler_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              colparIJrster;
    logic              ld_ij_par;
    logic              ld_prev;
    logic              colparDone;

    modport master (
        input  start, colparDone,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr,
               colparIJrster, ld_ij_par, ld_prev
    );

    modport slave (
        output start, colparDone,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr,
               colparIJrster, ld_ij_par, ld_prev
    );
endinterface

// File: rtl/colpar_slice_counter.sv
// Slice index k with clear, increment and last-slice flag.
module colpar_slice_counter #(
    parameter int SLICES = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] k,
    output logic              last
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            k <= '0;
        end else if (inc) begin
            k <= k + 1'b1;
        end
    end

    assign last = (k == ADDR_W'(SLICES - 1));

endmodule

// File: rtl/colpar_scheduler.sv
// Column-parity slice sequencer: walks SLICES slices through the theta datapath.
// Optional cycle counter enabled by defining COLPAR_SCHED_PERF_EN.
module colpar_scheduler
    import colpar_pkg::*;
#(
    parameter int SLICES = 64,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    colpar_scheduler_if.master      bus
`ifdef COLPAR_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]        cycle_count
`endif
);

    if (((1 << ADDR_W) < SLICES) || (CNT_W < 1)) begin : g_cfg_check
        $error("colpar_scheduler: ADDR_W too small for SLICES or CNT_W invalid");
    end

    colpar_state_t     state;
    colpar_state_t     state_d;
    logic [WDOG_W-1:0] wdog;
    logic [ADDR_W-1:0] k;
    logic              k_last;
    logic              k_clr;
    logic              k_inc;
    logic              busy;

    colpar_slice_counter #(
        .SLICES (SLICES),
        .ADDR_W (ADDR_W)
    ) u_slice_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (k_clr),
        .inc  (k_inc),
        .k    (k),
        .last (k_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Counts consecutive RUN cycles; a datapath that never signals completion is abandoned.
    always_ff @(posedge clk) begin
        if (rst || (state != RUN)) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        k_clr   = 1'b0;
        k_inc   = 1'b0;
        case (state)
            IDLE:    if (bus.start) state_d = PRE_RD;
            PRE_RD:  state_d = PRE_LD;
            PRE_LD: begin
                k_clr   = 1'b1;
                state_d = RD;
            end
            RD:      state_d = INIT;
            INIT:    state_d = RUN;
            RUN: begin
                if (bus.colparDone) begin
                    state_d = WR;
                end else if (wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
                    state_d = FIN;
                end
            end
            WR: begin
                if (k_last) begin
                    state_d = FIN;
                end else begin
                    k_inc   = 1'b1;
                    state_d = RD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every strobe is a pure decode of the state register.
    assign busy              = (state != IDLE) && (state != FIN);
    assign bus.busy          = busy;
    assign bus.done          = (state == FIN);
    assign bus.rd_en         = (state == PRE_RD) || (state == RD);
    assign bus.rd_addr       = (state == PRE_RD) ? ADDR_W'(SLICES - 1) : k;
    assign bus.ld_prev       = (state == PRE_LD) || (state == WR);
    assign bus.colparIJrster = (state == INIT);
    assign bus.ld_ij_par     = (state == INIT) || (state == RUN);
    assign bus.wr_en         = (state == WR);
    assign bus.wr_addr       = k;

`ifdef COLPAR_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
        end else if ((state == IDLE) && bus.start) begin
            cycle_count <= '0;
        end else if (busy && (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_colpar_scheduler.sv
// Directed bench for colpar_scheduler with an ideal 25-step datapath model.
module tb_colpar_scheduler;

    localparam int SLICES = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    int   step = 0;
    int   checks = 0;
    int   errors = 0;

    colpar_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef COLPAR_SCHED_PERF_EN
    logic [CNT_W-1:0] cycle_count;
`endif

    colpar_scheduler #(
        .SLICES (SLICES),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef COLPAR_SCHED_PERF_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    // Ideal datapath: index reset on INIT, final (I=4,J=4) step is the 25th RUN cycle.
    always @(posedge clk) begin
        if (bus.colparIJrster) step <= 0;
        else if (bus.ld_ij_par) step <= step + 1;
    end
    assign bus.colparDone = !stall && bus.ld_ij_par && !bus.colparIJrster && (step == 24);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, 64'(bus.busy), 0);
        check({tag, " done"}, 64'(bus.done), 0);
        check({tag, " rd_en"}, 64'(bus.rd_en), 0);
        check({tag, " wr_en"}, 64'(bus.wr_en), 0);
        check({tag, " ld_prev"}, 64'(bus.ld_prev), 0);
        check({tag, " ld_ij_par"}, 64'(bus.ld_ij_par), 0);
        check({tag, " ij_rst"}, 64'(bus.colparIJrster), 0);
    endtask

    task automatic run_pass(input string name, input int start_at, input int rst_at,
                            input int exp_done, input int exp_nwr, input int exp_nprev,
                            input int exp_cc);
        int n, nwr, order_err, nprev, gap, ndone, done_cyc, late;
        nwr = 0; order_err = 0; nprev = 0; gap = 0; ndone = 0; done_cyc = 0;
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        n = 1;
        check({name, " first rd_en"}, 64'(bus.rd_en), 1);
        check({name, " first rd_addr"}, 64'(bus.rd_addr), 63);
`ifdef COLPAR_SCHED_PERF_EN
        check({name, " cc cleared"}, 64'(cycle_count), 0);
`endif
        while (n <= 3000) begin
            if (n == 2) check({name, " wrap ld_prev"}, 64'(bus.ld_prev), 1);
            if (n == 3) begin
                check({name, " second rd_en"}, 64'(bus.rd_en), 1);
                check({name, " second rd_addr"}, 64'(bus.rd_addr), 0);
            end
            if (bus.wr_en) begin
                if (int'(bus.wr_addr) != nwr) order_err++;
                nwr++;
            end
            if (bus.ld_prev) nprev++;
            if (bus.done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = n;
`ifdef COLPAR_SCHED_PERF_EN
                check({name, " cc at done"}, 64'(cycle_count), 64'(exp_cc));
`endif
            end else if (!bus.busy) begin
                gap++;
            end
            bus.start = (n == start_at);
            if (n == rst_at) begin
                check({name, " in RUN before rst"}, 64'(bus.ld_ij_par), 1);
                rst = 1'b1;
            end
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (rst) begin
                check_quiet({name, " after rst"});
                rst = 1'b0;
                break;
            end
            if (done_cyc != 0) break;
        end
        check({name, " writes"}, 64'(nwr), 64'(exp_nwr));
        check({name, " write order errs"}, 64'(order_err), 0);
        check({name, " ld_prev pulses"}, 64'(nprev), 64'(exp_nprev));
        check({name, " busy gaps"}, 64'(gap), 0);
        if (rst_at == 0) begin
            check({name, " done cycle"}, 64'(done_cyc), 64'(exp_done));
            check({name, " done count"}, 64'(ndone), 1);
            check_quiet({name, " idle after done"});
`ifdef COLPAR_SCHED_PERF_EN
            repeat (3) @(negedge clk);
            check({name, " cc holds"}, 64'(cycle_count), 64'(exp_cc));
`endif
        end else begin
            late = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.done || bus.wr_en || bus.busy) late++;
            end
            check({name, " activity after rst"}, 64'(late), 0);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset rd_addr", 64'(bus.rd_addr), 0);
        check("reset wr_addr", 64'(bus.wr_addr), 0);
`ifdef COLPAR_SCHED_PERF_EN
        check("reset cc", 64'(cycle_count), 0);
`endif
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        run_pass("single", 0, 0, 1795, 64, 65, 1794);
        run_pass("start_busy", 100, 0, 1795, 64, 65, 1794);
        // Slice 10 RD is cycle 283, so RUN cycle 5 is cycle 289.
        run_pass("midrst", 0, 289, 0, 10, 11, 0);
        run_pass("after_rst", 0, 0, 1795, 64, 65, 1794);
        stall = 1'b1;
        run_pass("watchdog", 0, 0, 37, 0, 1, 36);
        stall = 1'b0;
        run_pass("recover", 0, 0, 1795, 64, 65, 1794);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colpar_scheduler.md
# colpar_scheduler

Sequencing controller for the column-parity (theta) slice datapath. Walks a state memory of `SLICES` 25-bit slices, feeds each slice to the datapath, drives its index-reset, step-enable and previous-slice-load strobes, and writes each finished slice to the result memory. Sits between the round controller (`start`/`done` handshake) and the column-parity datapath plus its two slice memories.

## Interface

**Parameters**
- `SLICES`, 64: number of 25-bit slices per state.
- `ADDR_W`, 6: slice address width; must satisfy 2^`ADDR_W` ≥ `SLICES`.
- `CNT_W`, 16: width of the performance counter (see Configuration).

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle request to process a full state; sampled only in IDLE.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse after the last slice is written.
- `rd_en`, output, 1: source-memory read strobe. Read latency is 1 cycle; data holds until the next `rd_en`.
- `rd_addr`, output, `ADDR_W`: source slice address.
- `wr_en`, output, 1: result-memory write strobe. The datapath `newSlice` output is the write data.
- `wr_addr`, output, `ADDR_W`: result slice address.
- `colparIJrster`, output, 1: datapath index reset; newSlice is loaded with the current slice.
- `ld_ij_par`, output, 1: datapath I/J step enable.
- `ld_prev`, output, 1: load datapath previous-slice register from current slice data.
- `colparDone`, input, 1: datapath flag, high during the final (I=4, J=4) step.
- `cycle_count`, output, `CNT_W`: present only with `COLPAR_SCHED_PERF_EN`.

## Operation

- Slice counter `k` spans 0..`SLICES`-1. Slice 0 uses slice `SLICES`-1 as its previous slice (wrap-around).
- **IDLE**: all strobes low. `start` → PRE_RD.
- **PRE_RD**: `rd_en`=1, `rd_addr`=`SLICES`-1. → PRE_LD.
- **PRE_LD**: `ld_prev`=1. Sets k=0. → RD.
- **RD**: `rd_en`=1, `rd_addr`=k. → INIT.
- **INIT**: `colparIJrster`=1, `ld_ij_par`=1 (I, J cleared; newSlice ← slice k). → RUN.
- **RUN**: `ld_ij_par`=1 each cycle. When `colparDone`=1 in this cycle (the last bit is written on this edge) → WR.
- **WR**: `wr_en`=1, `wr_addr`=k, `ld_prev`=1 (slice k becomes previous). If k=`SLICES`-1 → FIN; otherwise k←k+1 and → RD.
- **FIN**: `done`=1, `busy`=0. → IDLE.
- `start` while not in IDLE is ignored and not queued.
- Watchdog: if RUN lasts 32 cycles without `colparDone`, → FIN without writing the slice. Verification flags this as an error.
- All strobes are registered state decodes (Moore). No combinational path from `start` to any output.

## Timing

- Reset values: state=IDLE, k=0, all outputs 0, `cycle_count`=0.
- `rst` mid-operation: next cycle is IDLE with all strobes low. No `done` and no further writes.
- Per slice: RD 1 + INIT 1 + RUN 25 + WR 1 = 28 cycles.
- Total latency from `start` accepted to `done` pulse: 2 + 28·`SLICES` + 1 cycles (1795 for 64 slices).
- `wr_en` is asserted exactly once per slice, in address order 0..`SLICES`-1.
- `ld_prev` pulses `SLICES`+1 times per state.

## Configuration

- `COLPAR_SCHED_PERF_EN` defined:
  - `cycle_count` port exists.
  - Cleared on accepted `start`, increments every cycle while `busy`, holds after `done`.
  - Saturates at all-ones.
- Not defined: port, counter and logic are absent. All other behaviour is identical.

## Structure

- Shared package `colpar_pkg`:
  - state enum `colpar_state_t` (IDLE, PRE_RD, PRE_LD, RD, INIT, RUN, WR, FIN)
  - `LANES`=25
  - `RUN_STEPS`=25
  - `WDOG_LIMIT`=32
- One sub-module, `colpar_slice_counter`: slice index with clear, increment and last-slice flag.
- FSM, watchdog and perf counter live in the top module.

## Test plan

- **Reset then single start** (`SLICES`=64, ideal datapath model raising `colparDone` on the 25th step):
  - `done` arrives exactly 1795 cycles after the start edge.
  - 64 writes to addresses 0..63, in order.
- **Wrap-around**: first `rd_addr` after start is 63, followed by `ld_prev`. Next read is address 0, and the first write is address 0.
- **Start while busy**: pulse `start` at cycle 100. Ignored; exactly one `done`; `busy` is continuous.
- **Reset mid-operation**: assert `rst` at slice 10, RUN cycle 5.
  - Next cycle all strobes are 0 and state is IDLE.
  - A new start then produces a full 64-slice pass.
- **Watchdog**: hold `colparDone` low. FIN after 32 RUN cycles; `done` pulses; no `wr_en` for that slice.
- **Perf counter** (with `COLPAR_SCHED_PERF_EN`): `cycle_count`=1794 at `done`, holds afterwards, clears on the next start.
